ascon128_decrypt_seq: RTL and testbench

- Iterative, clocked ASCON-128 authenticated-decryption engine: init, associated data, ciphertext decrypt, finalization and tag check.
- One 320-bit state register, with ROUNDS_PER_CYCLE permutation rounds unrolled per clock.
- Accepts a variable number of 64-bit AD and ciphertext blocks over a valid/ready stream; emits plaintext blocks and a tag-match flag.
- Sits in the RECIEVER path as the sequential successor of the fixed-length combinational receiver chain.

---
 rtl/ascon128_decrypt_seq.sv | 188 ++++++++++++++++++
 tb/tb_ascon128_decrypt_seq.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon128_decrypt_seq.sv
// ascon128_decrypt_seq: iterative ASCON-128 authenticated decryption over a 64-bit AD/ciphertext stream
module ascon128_decrypt_seq #(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int PA_ROUNDS        = 12,
    parameter int PB_ROUNDS        = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [127:0] nonce,
    input  logic [127:0] tag_exp,
    input  logic         ad_en,
    input  logic         ct_en,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  in_data,
    input  logic         in_last,
    output logic         pt_valid,
    output logic [63:0]  pt_data,
    output logic         busy,
    output logic         done,
    output logic         tag_ok
);
    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_INIT    = 4'd1;
    localparam logic [3:0] S_AD_WAIT = 4'd2;
    localparam logic [3:0] S_AD_PERM = 4'd3;
    localparam logic [3:0] S_AD_PAD  = 4'd4;
    localparam logic [3:0] S_DSEP    = 4'd5;
    localparam logic [3:0] S_CT_WAIT = 4'd6;
    localparam logic [3:0] S_CT_PERM = 4'd7;
    localparam logic [3:0] S_CT_PAD  = 4'd8;
    localparam logic [3:0] S_FINAL   = 4'd9;
    localparam logic [3:0] S_DONE    = 4'd10;

    localparam logic [63:0] IV  = 64'h80400c0600000000;
    localparam logic [63:0] PAD = 64'h8000000000000000;
    // Every permutation ends at round index 11, so p^n starts at index 12-n.
    localparam logic [3:0] PA_START = 4'(12 - PA_ROUNDS);
    localparam logic [3:0] PB_START = 4'(12 - PB_ROUNDS);

    logic [3:0]   r_state;
    logic [319:0] r_s;
    logic [3:0]   r_rnd;
    logic [127:0] r_key;
    logic [127:0] r_tag;
    logic         r_ad_en;
    logic         r_ct_en;
    logic         r_last;
    logic         r_pt_valid;
    logic [63:0]  r_pt_data;
    logic         r_tag_ok;

    logic [319:0] w_pre;
    logic [319:0] w_chain [ROUNDS_PER_CYCLE+1];
    logic [319:0] w_perm;
    logic [4:0]   w_rnd_nx;
    logic         w_last;
    logic         w_perm_state;

    function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // One ASCON round: constant addition, bitsliced 5-bit S-box, linear diffusion.
    function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [7:0] c);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        x0 = s[319:256];
        x1 = s[255:192];
        x2 = s[191:128] ^ {56'd0, c};
        x3 = s[127:64];
        x4 = s[63:0];
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        return {x0 ^ rotr(x0, 19) ^ rotr(x0, 28),
                x1 ^ rotr(x1, 61) ^ rotr(x1, 39),
                x2 ^ rotr(x2, 1)  ^ rotr(x2, 6),
                x3 ^ rotr(x3, 10) ^ rotr(x3, 17),
                x4 ^ rotr(x4, 7)  ^ rotr(x4, 41)};
    endfunction

    // Padding and key injection that precede the first round of AD_PAD / FINAL are folded in front of the rounds.
    assign w_pre = (r_state == S_AD_PAD && r_rnd == PB_START) ? r_s ^ {PAD, 256'd0}
                 : (r_state == S_FINAL && r_rnd == PA_START)  ? r_s ^ {64'd0, r_key, 128'd0}
                 : r_s;

    assign w_chain[0] = w_pre;
    for (genvar i = 0; i < ROUNDS_PER_CYCLE; i++) begin : g_rnd
        logic [7:0] w_idx;
        assign w_idx          = {4'd0, r_rnd} + 8'(i);
        assign w_chain[i + 1] = ascon_round(w_chain[i], 8'hf0 - w_idx * 8'h0f);
    end

    assign w_perm       = w_chain[ROUNDS_PER_CYCLE];
    assign w_rnd_nx     = {1'b0, r_rnd} + 5'(ROUNDS_PER_CYCLE);
    assign w_last       = w_rnd_nx == 5'd12;
    assign w_perm_state = r_state == S_INIT || r_state == S_AD_PERM || r_state == S_AD_PAD ||
                          r_state == S_CT_PERM || r_state == S_FINAL;

    assign in_ready = r_state == S_AD_WAIT || r_state == S_CT_WAIT;
    assign busy     = r_state != S_IDLE && r_state != S_DONE;
    assign done     = r_state == S_DONE;
    assign pt_valid = r_pt_valid;
    assign pt_data  = r_pt_data;
    assign tag_ok   = r_tag_ok;

    // Control FSM and state register: absorb, decrypt, finalize, compare tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_s        <= '0;
            r_rnd      <= '0;
            r_key      <= '0;
            r_tag      <= '0;
            r_ad_en    <= 1'b0;
            r_ct_en    <= 1'b0;
            r_last     <= 1'b0;
            r_pt_valid <= 1'b0;
            r_pt_data  <= '0;
            r_tag_ok   <= 1'b0;
        end else begin
            r_pt_valid <= 1'b0;
            if (w_perm_state) begin
                r_s   <= (r_state == S_INIT && w_last) ? w_perm ^ {192'd0, r_key} : w_perm;
                r_rnd <= w_last ? PB_START : w_rnd_nx[3:0];
                if (w_last)
                    r_state <= r_state == S_INIT    ? (r_ad_en ? S_AD_WAIT : S_DSEP)
                             : r_state == S_AD_PERM ? (r_last ? S_AD_PAD : S_AD_WAIT)
                             : r_state == S_AD_PAD  ? S_DSEP
                             : r_state == S_CT_PERM ? (r_last ? S_CT_PAD : S_CT_WAIT)
                             : S_DONE;
                if (w_last && r_state == S_FINAL)
                    r_tag_ok <= (w_perm[127:0] ^ r_key) == r_tag;
            end else begin
                case (r_state)
                    S_IDLE: if (start) begin
                        r_state  <= S_INIT;
                        r_s      <= {IV, key, nonce};
                        r_rnd    <= PA_START;
                        r_key    <= key;
                        r_tag    <= tag_exp;
                        r_ad_en  <= ad_en;
                        r_ct_en  <= ct_en;
                        r_tag_ok <= 1'b0;
                    end
                    S_AD_WAIT: if (in_valid) begin
                        r_s[319:256] <= r_s[319:256] ^ in_data;
                        r_last       <= in_last;
                        r_state      <= S_AD_PERM;
                    end
                    S_DSEP: begin
                        r_s[0]  <= ~r_s[0];
                        r_state <= r_ct_en ? S_CT_WAIT : S_CT_PAD;
                    end
                    S_CT_WAIT: if (in_valid) begin
                        r_pt_data    <= r_s[319:256] ^ in_data;
                        r_pt_valid   <= 1'b1;
                        r_s[319:256] <= in_data;
                        r_last       <= in_last;
                        r_state      <= S_CT_PERM;
                    end
                    S_CT_PAD: begin
                        r_s[319:256] <= r_s[319:256] ^ PAD;
                        r_rnd        <= PA_START;
                        r_state      <= S_FINAL;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ascon128_decrypt_seq.sv
// tb_ascon128_decrypt_seq: checks ASCON-128 decryption for 1/2/3/6 rounds per cycle against a reference model
module tb_ascon128_decrypt_seq;
    localparam logic [63:0] IV  = 64'h80400c0600000000;
    localparam logic [63:0] PAD = 64'h8000000000000000;
    localparam logic [127:0] KAT = 128'h000102030405060708090a0b0c0d0e0f;

    logic clk = 1'b0;
    logic rst;
    logic [127:0] key, nonce, tag_exp;
    logic ad_en, ct_en, in_last;
    logic [63:0] in_data;
    logic start [4];
    logic in_valid [4];
    logic in_ready [4];
    logic pt_valid [4];
    logic busy [4];
    logic done [4];
    logic tag_ok [4];
    logic s_zero [4];
    logic [63:0] pt_data [4];
    logic [63:0] ad_q [4];
    logic [63:0] ct_q [4];
    logic [63:0] pt_q [4];
    logic [63:0] g_ad [4];
    logic [63:0] g_pt [4];
    int nad, nct, n_tests, n_fail;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        ascon128_decrypt_seq #(.ROUNDS_PER_CYCLE(g == 3 ? 6 : g + 1)) dut (
            .clk(clk), .rst(rst), .start(start[g]), .key(key), .nonce(nonce), .tag_exp(tag_exp),
            .ad_en(ad_en), .ct_en(ct_en), .in_valid(in_valid[g]), .in_ready(in_ready[g]),
            .in_data(in_data), .in_last(in_last), .pt_valid(pt_valid[g]), .pt_data(pt_data[g]),
            .busy(busy[g]), .done(done[g]), .tag_ok(tag_ok[g])
        );
        assign s_zero[g] = dut.r_s == 320'd0;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int rpc(input int u);
        return u == 3 ? 6 : u + 1;
    endfunction

    function automatic logic [63:0] ror(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic logic [319:0] perm(input logic [319:0] s, input int nr);
        logic [63:0] x [5];
        logic [63:0] t [5];
        for (int k = 0; k < 5; k++) x[k] = s[319 - 64 * k -: 64];
        for (int r = 12 - nr; r < 12; r++) begin
            x[2] ^= 64'(((15 - r) << 4) | r);
            x[0] ^= x[4]; x[4] ^= x[3]; x[2] ^= x[1];
            for (int k = 0; k < 5; k++) t[k] = ~x[k] & x[(k + 1) % 5];
            for (int k = 0; k < 5; k++) x[k] ^= t[(k + 1) % 5];
            x[1] ^= x[0]; x[0] ^= x[4]; x[3] ^= x[2]; x[2] = ~x[2];
            x[0] ^= ror(x[0], 19) ^ ror(x[0], 28);
            x[1] ^= ror(x[1], 61) ^ ror(x[1], 39);
            x[2] ^= ror(x[2], 1) ^ ror(x[2], 6);
            x[3] ^= ror(x[3], 10) ^ ror(x[3], 17);
            x[4] ^= ror(x[4], 7) ^ ror(x[4], 41);
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic logic [319:0] m_hdr();
        logic [319:0] s;
        s = perm({IV, key, nonce}, 12);
        s[127:0] ^= key;
        for (int i = 0; i < nad; i++) begin
            s[319:256] ^= ad_q[i];
            s = perm(s, 6);
        end
        if (nad > 0) begin
            s[319:256] ^= PAD;
            s = perm(s, 6);
        end
        s[0] = ~s[0];
        return s;
    endfunction

    function automatic logic [127:0] m_final(input logic [319:0] s);
        logic [319:0] f;
        f = s;
        f[319:256] ^= PAD;
        f[255:128] ^= key;
        f = perm(f, 12);
        return f[127:0] ^ key;
    endfunction

    task automatic prep();
        logic [319:0] s;
        s = m_hdr();
        for (int i = 0; i < nct; i++) begin
            s[319:256] ^= pt_q[i];
            ct_q[i] = s[319:256];
            s = perm(s, 6);
        end
        tag_exp = m_final(s);
    endtask

    task automatic run(input int u, input string tag, input int stall, input bit lat);
        logic [319:0] s;
        logic [63:0] ep [4];
        logic eok;
        int cyc, got, idx, sn, pc;
        bit acc, fin;
        string p;
        p = $sformatf("%s_r%0d", tag, rpc(u));
        s = m_hdr();
        for (int i = 0; i < nct; i++) begin
            ep[i] = s[319:256] ^ ct_q[i];
            s[319:256] = ct_q[i];
            s = perm(s, 6);
        end
        eok = m_final(s) == tag_exp;
        ad_en = nad > 0;
        ct_en = nct > 0;
        @(negedge clk);
        start[u] = 1'b1;
        cyc = 0; got = 0; idx = 0; sn = 0; pc = -1; acc = 0; fin = 0;
        while (!fin && cyc < 1000) begin
            @(posedge clk);
            #1;
            cyc++;
            start[u] = 1'b0;
            if (pc >= 0) pc++;
            if (acc) begin
                if (idx >= nad && idx < nad + nct - 1) pc = 0;
                idx++;
            end
            if (pc > 0 && in_ready[u]) begin
                chk({p, "_pb_cycles"}, 128'(pc), 128'(6 / rpc(u)));
                pc = -1;
            end
            if (cyc == 1) chk({p, "_busy"}, 128'(busy[u]), 128'(1));
            if (pt_valid[u]) begin
                if (got < nct) chk($sformatf("%s_pt%0d", p, got), 128'(pt_data[u]), 128'(ep[got]));
                else chk({p, "_pt_extra"}, 128'(got), 128'(nct));
                got++;
            end
            if (done[u]) begin
                fin = 1;
                chk({p, "_tag_ok"}, 128'(tag_ok[u]), 128'(eok));
                if (lat) chk({p, "_latency"}, 128'(cyc), 128'(2 * (12 / rpc(u)) + 3));
            end
            in_valid[u] = idx < nad + nct && !(idx == nad && sn < stall);
            in_data = idx < nad ? ad_q[idx & 3] : ct_q[(idx - nad) & 3];
            in_last = idx == nad - 1 || idx == nad + nct - 1;
            @(negedge clk);
            if (idx == nad && sn < stall && (in_ready[u] || sn > 0)) begin
                chk({p, "_stall_ready"}, 128'(in_ready[u]), 128'(1));
                chk({p, "_stall_ptv"}, 128'(pt_valid[u]), 128'(0));
                sn++;
            end
            acc = in_valid[u] && in_ready[u];
        end
        in_valid[u] = 1'b0;
        chk({p, "_finished"}, 128'(fin), 128'(1));
        chk({p, "_pt_count"}, 128'(got), 128'(nct));
        @(posedge clk);
        #1;
        chk({p, "_done_pulse"}, 128'(done[u]), 128'(0));
        chk({p, "_idle"}, 128'(busy[u]), 128'(0));
        chk({p, "_tag_hold"}, 128'(tag_ok[u]), 128'(eok));
    endtask

    task automatic reset_mid(input int u);
        string p;
        p = $sformatf("rstmid_r%0d", rpc(u));
        key = {$urandom(), $urandom(), $urandom(), $urandom()};
        nonce = {$urandom(), $urandom(), $urandom(), $urandom()};
        ad_en = 1'b0;
        ct_en = 1'b1;
        @(negedge clk);
        start[u] = 1'b1;
        @(negedge clk);
        start[u] = 1'b0;
        for (int i = 0; i < 200 && !in_ready[u]; i++) @(negedge clk);
        chk({p, "_wait"}, 128'(in_ready[u]), 128'(1));
        in_data = {$urandom(), $urandom()};
        in_last = 1'b0;
        in_valid[u] = 1'b1;
        @(negedge clk);
        in_valid[u] = 1'b0;
        chk({p, "_in_perm"}, 128'(pt_valid[u]), 128'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk({p, "_busy"}, 128'(busy[u]), 128'(0));
        chk({p, "_in_ready"}, 128'(in_ready[u]), 128'(0));
        chk({p, "_pt_valid"}, 128'(pt_valid[u]), 128'(0));
        chk({p, "_pt_data"}, 128'(pt_data[u]), 128'(0));
        chk({p, "_done"}, 128'(done[u]), 128'(0));
        chk({p, "_state_zero"}, 128'(s_zero[u]), 128'(1));
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        rst = 1'b1;
        key = '0; nonce = '0; tag_exp = '0;
        ad_en = 1'b0; ct_en = 1'b0; in_last = 1'b0; in_data = '0;
        for (int u = 0; u < 4; u++) begin
            start[u] = 1'b0;
            in_valid[u] = 1'b0;
            g_ad[u] = {$urandom(), $urandom()};
            g_pt[u] = {$urandom(), $urandom()};
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int u = 0; u < 4; u++) begin
            chk($sformatf("reset_busy_r%0d", rpc(u)), 128'(busy[u]), 128'(0));
            chk($sformatf("reset_ready_r%0d", rpc(u)), 128'(in_ready[u]), 128'(0));
            chk($sformatf("reset_ptv_r%0d", rpc(u)), 128'(pt_valid[u]), 128'(0));
            chk($sformatf("reset_done_r%0d", rpc(u)), 128'(done[u]), 128'(0));
            chk($sformatf("reset_tag_ok_r%0d", rpc(u)), 128'(tag_ok[u]), 128'(0));
            chk($sformatf("reset_state_r%0d", rpc(u)), 128'(s_zero[u]), 128'(1));
            key = '0; nonce = '0; nad = 0; nct = 0;
            prep();
            run(u, "empty", 0, 1);
            key = KAT; nonce = KAT; nad = 2; nct = 3;
            ad_q = g_ad;
            pt_q = g_pt;
            prep();
            run(u, "golden", 0, 0);
            ct_q[1][0] = ~ct_q[1][0];
            run(u, "flipped", 0, 0);
            ct_q[1][0] = ~ct_q[1][0];
            run(u, "stall", 5, 0);
            repeat (3) begin
                key = {$urandom(), $urandom(), $urandom(), $urandom()};
                nonce = {$urandom(), $urandom(), $urandom(), $urandom()};
                nad = $urandom_range(0, 3);
                nct = $urandom_range(0, 3);
                for (int i = 0; i < 4; i++) begin
                    ad_q[i] = {$urandom(), $urandom()};
                    pt_q[i] = {$urandom(), $urandom()};
                end
                prep();
                if ($urandom_range(0, 1) == 1) tag_exp[$urandom_range(0, 127)] ^= 1'b1;
                run(u, "random", 0, 0);
            end
            reset_mid(u);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
